// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: Z80 I/O port addresses, the bit
//               layout of the UART control/status register, and the default
//               receive FIFO depth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Z80 I/O port addresses
  localparam logic [7:0] IOADDR_UART_DATA = 8'h00;
  localparam logic [7:0] IOADDR_UART_CTRL = 8'h01;

  // CTRL register bit positions
  localparam int CTRL_BIT_DATA_AVAIL = 0;
  localparam int CTRL_BIT_TX_READY   = 2;

  // Default receive FIFO depth (log2 of the entry count)
  localparam int RX_FIFO_DEPTH_LOG2 = 4;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/sync_fifo_ram.sv
// ============================================================================
// Module      : sync_fifo_ram
// Description : 8-bit x 2^ADDR_W simple dual-port RAM. One write port and
//               one registered read port (read-before-write on an address
//               collision). No control logic, so it maps onto block RAM.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_raddr  - read address, sampled every clock
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_ram #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  localparam int c_ENTRIES = 1 << ADDR_W;

  logic [7:0] r_mem [c_ENTRIES];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule : sync_fifo_ram

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive byte buffer between uart_rx and the Z80 I/O read
//               path. A two-state ingest FSM takes one byte per
//               rx_data_ready occurrence and acknowledges it with rx_clear.
//               Bytes are held in a 2^DEPTH_LOG2 first-word-fall-through
//               FIFO backed by sync_fifo_ram.
// Build macro : UART_RX_FIFO_RTS_EN - adds the registered rts_n flow-control
//               output with hysteresis (stop when free <= RTS_MARGIN, resume
//               when free > 2*RTS_MARGIN). Without it rts_n is absent and
//               RTS_MARGIN is unused.
// Ports       : clk           - system clock
//               reset         - synchronous active-high reset
//               rx_data       - byte from uart_rx
//               rx_data_ready - uart_rx holds a byte
//               rx_clear      - acknowledge to uart_rx (ACK state)
//               rd_strobe     - one-cycle pop request
//               rd_data       - head-of-FIFO byte (valid with data_avail)
//               data_avail    - FIFO non-empty
//               fifo_full     - FIFO holds 2^DEPTH_LOG2 bytes
//               level         - occupancy 0..2^DEPTH_LOG2
//               overrun       - sticky byte-dropped flag
//               overrun_clr   - one-cycle clear of overrun (set wins)
//               rts_n         - flow control (UART_RX_FIFO_RTS_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
  parameter int RTS_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_ready,
  output logic                  rx_clear,
  input  logic                  rd_strobe,
  output logic [7:0]            rd_data,
  output logic                  data_avail,
  output logic                  fifo_full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overrun,
  input  logic                  overrun_clr
`ifdef UART_RX_FIFO_RTS_EN
  ,
  output logic                  rts_n
`endif
);

  localparam logic [DEPTH_LOG2:0] c_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_ACK  = 1'b1;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic                  w_ingest;

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [DEPTH_LOG2:0]   w_level_nxt;
  logic                  r_avail;
  logic                  r_full;
  logic                  r_overrun;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  logic                  r_byp_sel;
  logic [7:0]            r_byp_data;
  logic [7:0]            w_ram_q;

  // --------------------------------------------------------------------------
  // Ingest FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ingest FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (rx_data_ready)  w_state_nxt = c_ST_ACK;
      c_ST_ACK:  if (!rx_data_ready) w_state_nxt = c_ST_IDLE;
      default:                       w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Ingest FSM: outputs. A byte is taken only on the IDLE->ACK transition,
  // so a flag that stays high never causes a second push.
  always_comb begin
    rx_clear = 1'b0;
    w_ingest = 1'b0;
    case (r_state)
      c_ST_IDLE: w_ingest = rx_data_ready & ~reset;
      c_ST_ACK:  rx_clear = 1'b1;
      default:   rx_clear = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Push / pop qualification
  // --------------------------------------------------------------------------
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign w_pop  = rd_strobe & (r_level != '0) & ~reset;
  assign w_push = w_ingest & (~r_full | w_pop);
  assign w_drop = w_ingest & r_full & ~w_pop;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + 1'b1;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  // Read-address lookahead: the RAM is addressed with the pointer value the
  // head will have after this edge, so a popped entry's successor is already
  // on the RAM output one cycle later.
  assign w_rd_addr = w_pop ? (r_rd_ptr + 1'b1) : r_rd_ptr;

  // --------------------------------------------------------------------------
  // Pointers, occupancy and status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_avail   <= 1'b0;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_addr;
      r_level  <= w_level_nxt;
      r_avail  <= (w_level_nxt != '0);
      r_full   <= (w_level_nxt == c_DEPTH);
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write-to-read bypass. When the entry being written is the one the RAM is
  // reading this edge (FIFO empty, or emptied by a concurrent pop), the RAM
  // returns stale contents, so the incoming byte is presented instead. The
  // same path supplies the 8'h00 reset value on rd_data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_byp_sel  <= 1'b1;
      r_byp_data <= 8'h00;
    end else begin
      r_byp_sel  <= w_push & (r_wr_ptr == w_rd_addr);
      r_byp_data <= rx_data;
    end
  end

  sync_fifo_ram #(
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (rx_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

  assign rd_data    = r_byp_sel ? r_byp_data : w_ram_q;
  assign data_avail = r_avail;
  assign fifo_full  = r_full;
  assign level      = r_level;
  assign overrun    = r_overrun;

  // --------------------------------------------------------------------------
  // Optional RTS flow control with hysteresis
  // --------------------------------------------------------------------------
`ifdef UART_RX_FIFO_RTS_EN
  localparam int                  c_RTS_OFF_INT = 2 * RTS_MARGIN;
  localparam logic [DEPTH_LOG2:0] c_RTS_ON      = RTS_MARGIN[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] c_RTS_OFF     = c_RTS_OFF_INT[DEPTH_LOG2:0];

  logic [DEPTH_LOG2:0] w_free_nxt;
  logic                r_rts_n;

  assign w_free_nxt = c_DEPTH - w_level_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rts_n <= 1'b0;
    end else if (w_free_nxt <= c_RTS_ON) begin
      r_rts_n <= 1'b1;
    end else if (w_free_nxt > c_RTS_OFF) begin
      r_rts_n <= 1'b0;
    end
  end

  assign rts_n = r_rts_n;
`else
  // RTS_MARGIN has no function in this build.
  logic w_unused_rts_margin;
  assign w_unused_rts_margin = (RTS_MARGIN != 0);
`endif

endmodule : uart_rx_fifo

`default_nettype wire
